// File: rtl/rom_dl_dispatch.sv
// ioctl download dispatcher: region decode, byte-to-word packing,
// registered word write strobes, per-region completion and error flags.
module rom_dl_dispatch #(
  parameter int NUM_REGIONS = 4,
  parameter int ADDR_W = 25,
  parameter int WORD_BYTES = 1,
  parameter int OFFS_W = 16,
  parameter logic [NUM_REGIONS*8-1:0] REGION_INDEX = '0,
  parameter logic [NUM_REGIONS*ADDR_W-1:0] REGION_BASE = '0,
  parameter logic [NUM_REGIONS*ADDR_W-1:0] REGION_SIZE = '0
) (
  input  logic                    clk_49m,
  input  logic                    reset,
  input  logic                    ioctl_download,
  input  logic [7:0]              ioctl_index,
  input  logic [ADDR_W-1:0]       ioctl_addr,
  input  logic [7:0]              ioctl_data,
  input  logic                    ioctl_wr,
  output logic [NUM_REGIONS-1:0]  rom_cs,
  output logic                    rom_we,
  output logic [OFFS_W-1:0]       rom_addr,
  output logic [8*WORD_BYTES-1:0] rom_data,
  output logic [NUM_REGIONS-1:0]  region_done,
  output logic                    err_unmapped,
  output logic                    err_order,
  output logic                    err_overrun,
  output logic                    busy
);

  localparam int RW = (NUM_REGIONS > 1) ? $clog2(NUM_REGIONS) : 1;
  localparam int LW = (WORD_BYTES > 1) ? $clog2(WORD_BYTES) : 1;
  localparam int DW = 8 * WORD_BYTES;
  localparam logic [ADDR_W-1:0] WB_A = ADDR_W'(WORD_BYTES);
  localparam logic [LW-1:0] LAST_LANE = LW'(WORD_BYTES - 1);
  localparam logic [WORD_BYTES-1:0] FULL = '1;

  typedef enum logic {S_IDLE, S_PART} state_e;

  state_e                 state_q, state_d, st;
  logic [DW-1:0]          buf_q, buf_d, bf, nbuf;
  logic [WORD_BYTES-1:0]  mask_q, mask_d, mk, nmask, lane_oh;
  logic [RW-1:0]          kr_q, kr_d;
  logic [OFFS_W-1:0]      ko_q, ko_d;
  logic                   dv_q, dv_d;
  logic [RW-1:0]          dr_q, dr_d;
  logic [OFFS_W-1:0]      do_q, do_d;
  logic [DW-1:0]          dd_q, dd_d;
  logic                   dl_q, acc_q, acc_d;
  logic                   we_q, we_d;
  logic [NUM_REGIONS-1:0] cs_q, cs_d;
  logic [OFFS_W-1:0]      addr_q, addr_d;
  logic [DW-1:0]          data_q, data_d;
  logic [NUM_REGIONS-1:0] done_q, done_d;
  logic                   eu_q, eu_d, eo_q, eo_d, ev_q, ev_d;
  logic                   busy_q, busy_d;

  logic                   hit;
  logic [RW-1:0]          hit_r;
  logic [ADDR_W-1:0]      hit_off;
  logic [LW-1:0]          lane;
  logic [OFFS_W-1:0]      woff;
  logic                   rise, fall, wr_in, coll;
  logic                   em;
  logic [RW-1:0]          em_r;
  logic [OFFS_W-1:0]      em_o;
  logic [DW-1:0]          em_d;

  function automatic logic [OFFS_W-1:0] last_word(logic [RW-1:0] r);
    logic [ADDR_W-1:0] sz;
    sz = REGION_SIZE[ADDR_W*r +: ADDR_W];
    return OFFS_W'(sz / WB_A - ADDR_W'(1));
  endfunction

  // Scan high to low so the lowest matching region wins.
  always_comb begin
    hit = 1'b0;
    hit_r = '0;
    hit_off = '0;
    for (int i = NUM_REGIONS - 1; i >= 0; i--) begin
      if (ioctl_index == REGION_INDEX[8*i +: 8] &&
          ioctl_addr >= REGION_BASE[ADDR_W*i +: ADDR_W] &&
          (ioctl_addr - REGION_BASE[ADDR_W*i +: ADDR_W]) <
            REGION_SIZE[ADDR_W*i +: ADDR_W]) begin
        hit = 1'b1;
        hit_r = RW'(i);
        hit_off = ioctl_addr - REGION_BASE[ADDR_W*i +: ADDR_W];
      end
    end
  end

  assign lane = LW'(hit_off % WB_A);
  assign woff = OFFS_W'(hit_off / WB_A);
  assign lane_oh = WORD_BYTES'(1) << lane;

  always_comb begin
    rise = ioctl_download & ~dl_q;
    fall = ~ioctl_download & dl_q;
    wr_in = ioctl_download & ioctl_wr;
    acc_d = wr_in & ~acc_q;

    st = rise ? S_IDLE : state_q;
    bf = rise ? '0 : buf_q;
    mk = rise ? '0 : mask_q;

    state_d = st;
    buf_d = bf;
    mask_d = mk;
    kr_d = kr_q;
    ko_d = ko_q;
    dv_d = 1'b0;
    dr_d = dr_q;
    do_d = do_q;
    dd_d = dd_q;

    done_d = rise ? '0 : done_q;
    eu_d = ~rise & eu_q;
    eo_d = ~rise & eo_q;
    ev_d = ~rise & ev_q;

    em = 1'b0;
    em_r = '0;
    em_o = '0;
    em_d = '0;
    nbuf = '0;
    nmask = '0;
    coll = 1'b0;

    if (dv_q) begin
      em = 1'b1;
      em_r = dr_q;
      em_o = do_q;
      em_d = dd_q;
    end

    if (fall && st == S_PART) begin
      em = 1'b1;
      em_r = kr_q;
      em_o = ko_q;
      em_d = bf;
      eo_d = 1'b1;
      state_d = S_IDLE;
      buf_d = '0;
      mask_d = '0;
    end

    if (wr_in & acc_q) ev_d = 1'b1;
    if (acc_d & ~hit) eu_d = 1'b1;

    if (acc_d & hit) begin
      if (st == S_PART && (kr_q != hit_r || ko_q != woff)) begin
        coll = 1'b1;
        em = 1'b1;
        em_r = kr_q;
        em_o = ko_q;
        em_d = bf;
        eo_d = 1'b1;
      end else begin
        nbuf = bf;
        nmask = mk;
      end
      nbuf[8*lane +: 8] = ioctl_data;
      nmask = nmask | lane_oh;
      if (lane == LAST_LANE) begin
        if (nmask != FULL) eo_d = 1'b1;
        state_d = S_IDLE;
        buf_d = '0;
        mask_d = '0;
        // The flush owns this cycle's strobe; the new word goes next.
        if (coll) begin
          dv_d = 1'b1;
          dr_d = hit_r;
          do_d = woff;
          dd_d = nbuf;
        end else begin
          em = 1'b1;
          em_r = hit_r;
          em_o = woff;
          em_d = nbuf;
        end
      end else begin
        state_d = S_PART;
        buf_d = nbuf;
        mask_d = nmask;
        kr_d = hit_r;
        ko_d = woff;
      end
    end

    we_d = em;
    cs_d = em ? (NUM_REGIONS'(1) << em_r) : '0;
    addr_d = em ? em_o : '0;
    data_d = em ? em_d : '0;
    if (em && em_o == last_word(em_r)) done_d[em_r] = 1'b1;
    busy_d = (state_d == S_PART) | em | dv_d;
  end

  always_ff @(posedge clk_49m or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      buf_q <= '0;
      mask_q <= '0;
      kr_q <= '0;
      ko_q <= '0;
      dv_q <= 1'b0;
      dr_q <= '0;
      do_q <= '0;
      dd_q <= '0;
      dl_q <= 1'b0;
      acc_q <= 1'b0;
      we_q <= 1'b0;
      cs_q <= '0;
      addr_q <= '0;
      data_q <= '0;
      done_q <= '0;
      eu_q <= 1'b0;
      eo_q <= 1'b0;
      ev_q <= 1'b0;
      busy_q <= 1'b0;
    end else begin
      state_q <= state_d;
      buf_q <= buf_d;
      mask_q <= mask_d;
      kr_q <= kr_d;
      ko_q <= ko_d;
      dv_q <= dv_d;
      dr_q <= dr_d;
      do_q <= do_d;
      dd_q <= dd_d;
      dl_q <= ioctl_download;
      acc_q <= acc_d;
      we_q <= we_d;
      cs_q <= cs_d;
      addr_q <= addr_d;
      data_q <= data_d;
      done_q <= done_d;
      eu_q <= eu_d;
      eo_q <= eo_d;
      ev_q <= ev_d;
      busy_q <= busy_d;
    end
  end

  assign rom_we = we_q;
  assign rom_cs = cs_q;
  assign rom_addr = addr_q;
  assign rom_data = data_q;
  assign region_done = done_q;
  assign err_unmapped = eu_q;
  assign err_order = eo_q;
  assign err_overrun = ev_q;
  assign busy = busy_q;

endmodule

// File: tb/tb_rom_dl_dispatch.sv
// Bench for rom_dl_dispatch: byte-mode and 2-byte-word instances share
// one ioctl stream and are scored against a per-config write model.
module tb_rom_dl_dispatch;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic dl = 1'b0;
  logic [7:0] idx = '0;
  logic [24:0] ad = '0;
  logic [7:0] dt = '0;
  logic wr = 1'b0;

  logic [3:0] b_cs, w_cs, b_dn, w_dn;
  logic b_we, w_we;
  logic [15:0] b_ad, w_ad;
  logic [7:0] b_dt;
  logic [15:0] w_dt;
  logic b_eu, b_eo, b_ev, b_bz;
  logic w_eu, w_eo, w_ev, w_bz;

  int n_run = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  rom_dl_dispatch #(
    .NUM_REGIONS(4), .ADDR_W(25), .WORD_BYTES(1), .OFFS_W(16),
    .REGION_INDEX({8'd2, 8'd2, 8'd1, 8'd0}),
    .REGION_BASE({25'h18, 25'h10, 25'h0, 25'h0}),
    .REGION_SIZE({25'h20, 25'h10, 25'h2000, 25'h2000})
  ) u_b (
    .clk_49m(clk), .reset(rst_n), .ioctl_download(dl),
    .ioctl_index(idx), .ioctl_addr(ad), .ioctl_data(dt),
    .ioctl_wr(wr), .rom_cs(b_cs), .rom_we(b_we), .rom_addr(b_ad),
    .rom_data(b_dt), .region_done(b_dn), .err_unmapped(b_eu),
    .err_order(b_eo), .err_overrun(b_ev), .busy(b_bz)
  );

  rom_dl_dispatch #(
    .NUM_REGIONS(4), .ADDR_W(25), .WORD_BYTES(2), .OFFS_W(16),
    .REGION_INDEX({8'd0, 8'd2, 8'd1, 8'd0}),
    .REGION_BASE({25'h4000, 25'h100, 25'h0, 25'h4000}),
    .REGION_SIZE({25'h100, 25'h40, 25'h2000, 25'h2000})
  ) u_w (
    .clk_49m(clk), .reset(rst_n), .ioctl_download(dl),
    .ioctl_index(idx), .ioctl_addr(ad), .ioctl_data(dt),
    .ioctl_wr(wr), .rom_cs(w_cs), .rom_we(w_we), .rom_addr(w_ad),
    .rom_data(w_dt), .region_done(w_dn), .err_unmapped(w_eu),
    .err_order(w_eo), .err_overrun(w_ev), .busy(w_bz)
  );

  int m_wb[2] = '{1, 2};
  int unsigned m_idx[2][4] = '{'{0, 1, 2, 2}, '{0, 1, 2, 0}};
  int unsigned m_base[2][4] = '{'{0, 0, 'h10, 'h18}, '{'h4000, 0, 'h100, 'h4000}};
  int unsigned m_size[2][4] = '{'{'h2000, 'h2000, 'h10, 'h20}, '{'h2000, 'h2000, 'h40, 'h100}};

  bit m_dlq, m_accq;
  bit pt[2];
  int pr[2], po[2];
  logic [7:0] pb[2][4];
  bit ph[2][4];
  bit dv[2], dinc[2];
  int dr[2], dof[2];
  logic [31:0] dd[2];

  bit x_we[2], x_eu[2], x_eo[2], x_ev[2], x_bz[2];
  logic [3:0] x_cs[2], x_dn[2];
  logic [15:0] x_ad[2];
  logic [31:0] x_dt[2];

  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s @%0t: got %h, want %h", tag, $time, got, exp);
    end
  endtask

  task automatic clr(int c);
    for (int l = 0; l < 4; l++) begin
      ph[c][l] = 1'b0;
      pb[c][l] = '0;
    end
  endtask

  task automatic mreset();
    m_dlq = 1'b0;
    m_accq = 1'b0;
    for (int c = 0; c < 2; c++) begin
      pt[c] = 1'b0; dv[c] = 1'b0; clr(c);
      x_we[c] = 1'b0; x_cs[c] = '0; x_ad[c] = '0; x_dt[c] = '0;
      x_dn[c] = '0; x_eu[c] = 1'b0; x_eo[c] = 1'b0;
      x_ev[c] = 1'b0; x_bz[c] = 1'b0;
    end
  endtask

  task automatic pack(int c, output logic [31:0] d, output bit inc);
    d = '0;
    inc = 1'b0;
    for (int l = 0; l < m_wb[c]; l++)
      if (ph[c][l]) d[8*l +: 8] = pb[c][l];
      else inc = 1'b1;
  endtask

  task automatic emit(int c, int r, int o, logic [31:0] d, bit inc);
    x_we[c] = 1'b1;
    x_cs[c] = 4'(1 << r);
    x_ad[c] = 16'(o);
    x_dt[c] = d;
    if (inc) x_eo[c] = 1'b1;
    if (o == int'(m_size[c][r]) / m_wb[c] - 1) x_dn[c][r] = 1'b1;
  endtask

  task automatic flush(int c);
    logic [31:0] d;
    bit inc;
    pack(c, d, inc);
    emit(c, pr[c], po[c], d, inc);
    pt[c] = 1'b0;
    clr(c);
  endtask

  // One clock of the model: inputs now, outputs as seen after the edge.
  task automatic mdl(int c, bit rise, bit fall, bit acc, bit ovr);
    int r, off, lane, w;
    bit coll;
    logic [31:0] d;
    bit inc;
    x_we[c] = 1'b0; x_cs[c] = '0; x_ad[c] = '0; x_dt[c] = '0;
    if (rise) begin
      x_dn[c] = '0; x_eu[c] = 1'b0; x_eo[c] = 1'b0; x_ev[c] = 1'b0;
      pt[c] = 1'b0; clr(c);
    end
    if (dv[c]) begin
      emit(c, dr[c], dof[c], dd[c], dinc[c]);
      dv[c] = 1'b0;
    end
    if (fall && pt[c]) flush(c);
    if (ovr) x_ev[c] = 1'b1;
    if (acc) begin
      r = -1;
      for (int k = 3; k >= 0; k--)
        if (idx == m_idx[c][k] && ad >= m_base[c][k] &&
            ad < m_base[c][k] + m_size[c][k]) r = k;
      if (r < 0) x_eu[c] = 1'b1;
      else begin
        off = int'(ad) - int'(m_base[c][r]);
        lane = off % m_wb[c];
        w = off / m_wb[c];
        coll = 1'b0;
        if (pt[c] && (pr[c] != r || po[c] != w)) begin
          flush(c);
          coll = 1'b1;
        end
        pb[c][lane] = dt;
        ph[c][lane] = 1'b1;
        pt[c] = 1'b1; pr[c] = r; po[c] = w;
        if (lane == m_wb[c] - 1) begin
          pack(c, d, inc);
          if (coll) begin
            dv[c] = 1'b1; dr[c] = r; dof[c] = w; dd[c] = d; dinc[c] = inc;
          end else emit(c, r, w, d, inc);
          pt[c] = 1'b0;
          clr(c);
        end
      end
    end
    x_bz[c] = pt[c] || x_we[c] || dv[c];
  endtask

  task automatic check_dut(int c, logic we, logic [3:0] cs, logic [15:0] a,
                           logic [15:0] d, logic [3:0] dn, logic eu,
                           logic eo, logic ev, logic bz);
    string p;
    p = (c == 0) ? "byte" : "word";
    chk({p, ".we"}, 32'(we), 32'(x_we[c]));
    chk({p, ".cs"}, 32'(cs), 32'(x_cs[c]));
    if (x_we[c]) begin
      chk({p, ".addr"}, 32'(a), 32'(x_ad[c]));
      chk({p, ".data"}, 32'(d), x_dt[c]);
    end
    chk({p, ".done"}, 32'(dn), 32'(x_dn[c]));
    chk({p, ".err_unmapped"}, 32'(eu), 32'(x_eu[c]));
    chk({p, ".err_order"}, 32'(eo), 32'(x_eo[c]));
    chk({p, ".err_overrun"}, 32'(ev), 32'(x_ev[c]));
    chk({p, ".busy"}, 32'(bz), 32'(x_bz[c]));
  endtask

  task automatic check_all();
    check_dut(0, b_we, b_cs, b_ad, 16'(b_dt), b_dn, b_eu, b_eo, b_ev, b_bz);
    check_dut(1, w_we, w_cs, w_ad, w_dt, w_dn, w_eu, w_eo, w_ev, w_bz);
  endtask

  task automatic step(bit d, int i, int a, int v, bit w);
    bit rise, fall, win, acc;
    dl = d;
    idx = 8'(i);
    ad = 25'(a);
    dt = 8'(v);
    wr = w;
    if (!rst_n) mreset();
    else begin
      rise = d && !m_dlq;
      fall = !d && m_dlq;
      win = d && w;
      acc = win && !m_accq;
      for (int c = 0; c < 2; c++) mdl(c, rise, fall, acc, win && m_accq);
      m_dlq = d;
      m_accq = acc;
    end
    @(posedge clk);
    #1;
    check_all();
  endtask

  int pick_idx[4] = '{0, 1, 2, 5};

  initial begin
    int la, ci, c, k;
    bit cd;
    mreset();
    for (int n = 0; n < 3; n++) step(0, 0, 0, 0, 0);
    rst_n = 1'b1;
    step(0, 0, 0, 0, 0);

    // byte mode
    step(1, 1, 'h10, 'hA5, 1);
    chk("bm.we", 32'(b_we), 32'd1);
    chk("bm.cs", 32'(b_cs), 32'b0010);
    chk("bm.addr", 32'(b_ad), 32'h10);
    chk("bm.data", 32'(b_dt), 32'hA5);

    // word packing
    step(0, 0, 0, 0, 0);
    step(1, 0, 'h4006, 'h34, 1);
    chk("wp.first_no_we", 32'(w_we), 32'd0);
    step(1, 0, 0, 0, 0);
    step(1, 0, 'h4007, 'h12, 1);
    chk("wp.we", 32'(w_we), 32'd1);
    chk("wp.addr", 32'(w_ad), 32'd3);
    chk("wp.data", 32'(w_dt), 32'h1234);

    // collision flush
    step(1, 0, 0, 0, 0);
    step(1, 0, 'h4006, 'h34, 1);
    step(1, 0, 0, 0, 0);
    step(1, 0, 'h4008, 'h78, 1);
    chk("cf.we", 32'(w_we), 32'd1);
    chk("cf.addr", 32'(w_ad), 32'd3);
    chk("cf.data", 32'(w_dt), 32'h0034);
    chk("cf.err_order", 32'(w_eo), 32'd1);
    step(1, 0, 0, 0, 0);
    chk("cf.no_we", 32'(w_we), 32'd0);
    step(1, 0, 'h4009, 'h56, 1);
    chk("cf.hi_data", 32'(w_dt), 32'h5678);

    // unmapped and gated
    step(0, 0, 0, 0, 0);
    step(1, 5, 0, 'h77, 1);
    chk("um.err_b", 32'(b_eu), 32'd1);
    chk("um.err_w", 32'(w_eu), 32'd1);
    step(0, 5, 0, 'h55, 1);
    step(0, 1, 'h10, 'h55, 1);
    chk("gate.we_b", 32'(b_we), 32'd0);
    chk("gate.we_w", 32'(w_we), 32'd0);

    // fill region 0 of the word instance
    for (int n = 0; n < 'h2000; n++) begin
      step(1, 0, 'h4000 + n, int'($urandom_range(0, 255)), 1);
      step(1, 0, 0, 0, 0);
    end
    chk("fill.done", 32'(w_dn), 32'b0001);
    step(0, 0, 0, 0, 0);
    chk("fill.done_hold", 32'(w_dn), 32'b0001);
    step(1, 0, 'h4000, 'h9C, 1);
    step(1, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0);
    chk("ef.we", 32'(w_we), 32'd1);
    chk("ef.data", 32'(w_dt), 32'h009C);
    chk("ef.err_order", 32'(w_eo), 32'd1);
    step(0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0);
    chk("ef.clear_eo", 32'(w_eo), 32'd0);
    chk("ef.clear_done", 32'(w_dn), 32'd0);

    // overrun
    step(1, 1, 'h20, 'hAA, 1);
    step(1, 1, 'h21, 'hBB, 1);
    chk("ov.err_b", 32'(b_ev), 32'd1);
    chk("ov.err_w", 32'(w_ev), 32'd1);
    step(1, 1, 0, 0, 0);
    chk("ov.dropped", 32'(b_we), 32'd0);

    // randomized traffic
    la = 0;
    cd = 1'b1;
    ci = 1;
    for (int n = 0; n < 4000; n++) begin
      if ($urandom_range(0, 63) == 0) begin
        cd = !cd;
        if (cd) ci = pick_idx[$urandom_range(0, 3)];
      end
      if ($urandom_range(0, 1) == 1) la = la + 1;
      else begin
        c = int'($urandom_range(0, 1));
        k = int'($urandom_range(0, 3));
        la = int'(m_base[c][k]) + int'($urandom_range(0, 40)) - 1;
      end
      step(cd, ci, la, int'($urandom_range(0, 255)),
           bit'($urandom_range(0, 1)));
    end

    // reset in the middle of a word
    step(0, 0, 0, 0, 0);
    step(1, 0, 'h4006, 'h11, 1);
    #1;
    rst_n = 1'b0;
    mreset();
    #1;
    check_all();
    step(1, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0);
    chk("rst.no_we", 32'(w_we), 32'd0);
    chk("rst.busy", 32'(w_bz), 32'd0);
    #2;
    rst_n = 1'b1;
    step(0, 0, 0, 0, 0);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule

// File: doc/rom_dl_dispatch.md
# rom_dl_dispatch

Parametrised download dispatcher between the MiSTer ioctl byte stream and the per-board ROM/RAM images of an arcade core. It replaces fixed address/index decoders with a table of `NUM_REGIONS` regions, each matched on download index plus an address window. It packs bytes into `WORD_BYTES`-wide words, issues one registered write strobe per completed word, and reports per-region completion plus sticky error flags. It sits between the HPS ioctl port and the CPU and sound board ROM write ports, in place of per-index write gating.

## Interface
Parameters:
- `NUM_REGIONS`, 4: number of decoded regions (1..16).
- `ADDR_W`, 25: ioctl address width.
- `WORD_BYTES`, 1: bytes per output word (1, 2 or 4).
- `OFFS_W`, 16: width of the region-relative word address.
- `REGION_INDEX`, 0: packed `NUM_REGIONS`×8 bits; ioctl index matched by region i is in bits [8i+7:8i].
- `REGION_BASE`, 0: packed `NUM_REGIONS`×`ADDR_W` bits; first byte address of each region.
- `REGION_SIZE`, 0: packed `NUM_REGIONS`×`ADDR_W` bits; region length in bytes, a multiple of `WORD_BYTES`, nonzero.

Ports:
- `clk_49m` in 1: system clock.
- `reset` in 1: asynchronous, active-low reset.
- `ioctl_download` in 1: download in progress.
- `ioctl_index` in 8: download index.
- `ioctl_addr` in `ADDR_W`: byte address.
- `ioctl_data` in 8: byte data.
- `ioctl_wr` in 1: single-cycle byte strobe.
- `rom_cs` out `NUM_REGIONS`: one-hot region select, valid with `rom_we`.
- `rom_we` out 1: single-cycle word write strobe.
- `rom_addr` out `OFFS_W`: word offset within the region, computed as (addr−base)/`WORD_BYTES`.
- `rom_data` out 8×`WORD_BYTES`: little-endian packed word; lane 0 is the lowest address.
- `region_done` out `NUM_REGIONS`: sticky; the region's last word has been written.
- `err_unmapped` out 1: sticky; a byte matched no region.
- `err_order` out 1: sticky; a partial word was flushed.
- `err_overrun` out 1: sticky; `ioctl_wr` pulses arrived too close together.
- `busy` out 1: a partial word is pending or a write is in flight.

## Operation
- **Region match.** Region i matches when `ioctl_index` == REGION_INDEX[i] and base ≤ `ioctl_addr` < base+size.
  - If regions overlap, the lowest i wins.
  - A byte that matches no region is dropped and sets `err_unmapped`.
- **Lane.** A byte's lane is (addr−base) mod `WORD_BYTES`; its word key is (region, word offset).
- **Packing state.** The packer holds a lane buffer, a valid mask, and the pending key. It has two states, IDLE and PARTIAL.
  - IDLE with an accepted byte: store the byte in its lane, then go to PARTIAL. If the lane is `WORD_BYTES`−1, emit the word immediately and stay in IDLE.
  - PARTIAL with a byte of the same key: store it. If the lane is `WORD_BYTES`−1, emit the word and go to IDLE.
  - PARTIAL with a byte of a different key: first flush the pending word, with missing lanes written as 0x00, and set `err_order`. Then handle the new byte as in IDLE. Its own write, if it completes a word, is issued one cycle later.
  - A final lane that arrives while earlier lanes are missing emits the word zero-padded and sets `err_order`.
- **Falling `ioctl_download`.** If PARTIAL, flush with zero padding, set `err_order`, and go to IDLE.
- **Gating.** `ioctl_wr` while `ioctl_download`=0 is ignored.
- **Overrun.** Accepted `ioctl_wr` pulses must be at least 2 cycles apart. A pulse arriving one cycle after an accepted pulse is dropped and sets `err_overrun`.
- **Region done.** `region_done[i]` sets on a write to region i whose `rom_addr` equals size/`WORD_BYTES`−1.
- **Flag clearing.** A rising edge of `ioctl_download` clears all `region_done` bits and all error flags, and forces IDLE.
- **`WORD_BYTES`=1.** Every accepted byte is written directly; `err_order` never sets.

## Timing
- **Reset values.** All outputs are 0. The packer is in IDLE with an empty mask. Reset mid-word discards the partial word and issues no write.
- **Latency.** `rom_we`, `rom_cs`, `rom_addr` and `rom_data` are registered. A word is written 1 cycle after the `ioctl_wr` that completes it.
  - A collision flush is written 1 cycle after the colliding byte. The colliding byte's completion write follows at +2.
  - An end-of-download flush is written 1 cycle after `ioctl_download` falls.
- **Strobe shape.** `rom_we` is high for exactly one cycle per word. `rom_cs`, `rom_addr` and `rom_data` are valid only in that cycle. `rom_cs` is 0 when `rom_we` is 0.
- **Error flags.** Each sets in the cycle after its cause and holds until the next download start or reset.
- **`busy`.** High from the first byte of a partial word until the cycle after its write.
- **Arithmetic.** Offsets are computed at `ADDR_W` bits and truncated to `OFFS_W`. REGION_SIZE/`WORD_BYTES` must fit in 2^`OFFS_W`.

## Test plan
- **Byte mode.** `WORD_BYTES`=1; region 0 is index 0, base 0x0000, size 0x2000; region 1 is index 1, base 0, size 0x2000. Download index 1, writing byte 0xA5 to address 0x0010 -> one cycle later, `rom_we`=1, `rom_cs`=2'b10, `rom_addr`=0x0010, `rom_data`=0xA5.
- **Word packing.** `WORD_BYTES`=2; region 0 has base 0x4000. Write 0x34 to 0x4006, then 0x12 to 0x4007 -> a single write with `rom_addr`=3 and `rom_data`=0x1234, issued one cycle after the second byte.
- **Collision flush.** Write 0x34 to 0x4006, then 0x78 to 0x4008 -> a write of offset 3 with data 0x0034 at +1, and `err_order`=1. No write for 0x4008 until its high byte arrives.
- **Unmapped and gated.** Download index 5 writing to address 0 -> no `rom_we`, `err_unmapped`=1. A write while `ioctl_download`=0 -> nothing.
- **Completion and end flush.** Fill all 0x2000 bytes of region 0 -> `region_done[0]`=1 on the last word. Then start a download ending on an odd byte at 0x4000 -> flush write on the `ioctl_download` fall, `err_order`=1. A new download start clears both flags.
- **Overrun and reset.** `ioctl_wr` on two consecutive cycles -> the second byte is dropped and `err_overrun`=1. Assert `reset`=0 during PARTIAL -> no write, and all outputs read 0.
